// File: rtl/bcd_score_counter.sv
// Two-digit BCD score (00..99) driven by three raw push-buttons.
// Each button is synchronised, debounced and edge-detected into a single event.
module bcd_score_counter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit WRAP            = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       clr_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       limit_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int INC = 0;
    localparam int DEC = 1;
    localparam int CLR = 2;

    logic [2:0]    raw;
    logic [2:0]    s1_q, s2_q;
    logic [2:0]    stable_q, stable_d;
    logic [2:0]    stable_dly_q;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    evt;

    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          limit_q, limit_d;

    assign raw = {clr_i, dec_i, inc_i};

    // The counter reaching DEBOUNCE_CYCLES is the same cycle it would wrap,
    // so the new level is accepted when the old value is DEBOUNCE_CYCLES-1.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign evt = stable_q & ~stable_dly_q;

    always_comb begin
        tens_d  = tens_q;
        ones_d  = ones_q;
        limit_d = 1'b0;
        if (evt[CLR]) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (evt[INC] && evt[DEC]) begin
            tens_d = tens_q;
        end else if (evt[INC]) begin
            if (ones_q < 4'd9) begin
                ones_d = ones_q + 4'd1;
            end else if (tens_q < 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                limit_d = 1'b1;
                if (WRAP) begin
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                end
            end
        end else if (evt[DEC]) begin
            if (ones_q > 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else if (tens_q > 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                limit_d = 1'b1;
                if (WRAP) begin
                    tens_d = 4'd9;
                    ones_d = 4'd9;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            limit_q      <= 1'b0;
        end else begin
            s1_q         <= raw;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            limit_q      <= limit_d;
        end
    end

    assign tens_o  = tens_q;
    assign ones_o  = ones_q;
    assign limit_o = limit_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Randomised scoreboard bench for bcd_score_counter: a saturating and a wrapping
// instance share the buttons and are checked against a plain-integer score model.
module tb_bcd_score_counter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] tens0, ones0, tens1, ones1;
    logic       lim0, lim1;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    // Entry layout: {check cycle[31:0], tens[3:0], ones[3:0], limit}
    logic [40:0] exp0_q[$];
    logic [40:0] exp1_q[$];

    int m0 = 0;
    int m1 = 0;

    bcd_score_counter #(.DEBOUNCE_CYCLES(N), .WRAP(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .clr_i(clr),
        .tens_o(tens0), .ones_o(ones0), .limit_o(lim0)
    );

    bcd_score_counter #(.DEBOUNCE_CYCLES(N), .WRAP(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .clr_i(clr),
        .tens_o(tens1), .ones_o(ones1), .limit_o(lim1)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic void apply(input int cnt_in, input bit w, input bit pi, input bit pd,
                                  input bit pc, output int cnt_out, output bit lim);
        cnt_out = cnt_in;
        lim     = 1'b0;
        if (pc) begin
            cnt_out = 0;
        end else if (pi && pd) begin
            cnt_out = cnt_in;
        end else if (pi) begin
            if (cnt_in == 99) begin
                lim = 1'b1;
                cnt_out = w ? 0 : 99;
            end else begin
                cnt_out = cnt_in + 1;
            end
        end else if (pd) begin
            if (cnt_in == 0) begin
                lim = 1'b1;
                cnt_out = w ? 99 : 0;
            end else begin
                cnt_out = cnt_in - 1;
            end
        end
    endfunction

    function automatic logic [40:0] mk(input int c, input int cnt, input bit lim);
        logic [31:0] cc;
        cc = c;
        return {cc, 4'(cnt / 10), 4'(cnt % 10), lim};
    endfunction

    function automatic int long_hold();
        return int'($urandom_range(N + 2, N + 8));
    endfunction

    // ---------------- driver ----------------
    task automatic press(input bit pi, input bit pd, input bit pc, input int hold, input int extra);
        int c;
        int n0, n1;
        bit l0, l1;
        @(negedge clk);
        c = cyc;
        inc = pi;
        dec = pd;
        clr = pc;
        l0 = 1'b0;
        l1 = 1'b0;
        if (hold >= N + 2) begin
            apply(m0, 1'b0, pi, pd, pc, n0, l0);
            apply(m1, 1'b1, pi, pd, pc, n1, l1);
            m0 = n0;
            m1 = n1;
        end
        exp0_q.push_back(mk(c + N + 3, m0, l0));
        exp1_q.push_back(mk(c + N + 3, m1, l1));
        if (extra > N + 3) begin
            exp0_q.push_back(mk(c + extra, m0, 1'b0));
            exp1_q.push_back(mk(c + extra, m1, 1'b0));
        end
        repeat (hold) @(negedge clk);
        inc = 1'b0;
        dec = 1'b0;
        clr = 1'b0;
        repeat (N + 4 + int'($urandom_range(0, 3))) @(negedge clk);
    endtask

    task automatic incs(input int k);
        for (int i = 0; i < k; i++) press(1'b1, 1'b0, 1'b0, long_hold(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int n0, n1;
        bit l0, l1;
        int op;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        press(1'b1, 1'b0, 1'b0, 20, 19);
        press(1'b1, 1'b0, 1'b0, long_hold(), 0);
        press(1'b1, 1'b0, 1'b0, 3, 0);
        press(1'b1, 1'b0, 1'b0, 1, 0);

        incs(7);
        press(1'b1, 1'b0, 1'b0, long_hold(), 0);
        press(1'b0, 1'b1, 1'b0, long_hold(), 0);
        press(1'b0, 1'b0, 1'b1, long_hold(), 0);
        press(1'b0, 1'b1, 1'b0, long_hold(), 0);
        press(1'b1, 1'b0, 1'b0, long_hold(), 0);

        press(1'b0, 1'b0, 1'b1, long_hold(), 0);
        incs(99);
        press(1'b1, 1'b0, 1'b0, long_hold(), 0);

        press(1'b0, 1'b0, 1'b1, long_hold(), 0);
        incs(42);
        press(1'b1, 1'b1, 1'b0, long_hold(), 0);
        press(1'b1, 1'b0, 1'b1, long_hold(), 0);
        incs(42);

        // Reset while an increment is still being debounced, button kept held.
        @(negedge clk);
        inc = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        m0 = 0;
        m1 = 0;
        @(negedge clk);
        rst = 1'b0;
        c = cyc;
        apply(m0, 1'b0, 1'b1, 1'b0, 1'b0, n0, l0);
        apply(m1, 1'b1, 1'b1, 1'b0, 1'b0, n1, l1);
        exp0_q.push_back(mk(c + 1, 0, 1'b0));
        exp1_q.push_back(mk(c + 1, 0, 1'b0));
        m0 = n0;
        m1 = n1;
        exp0_q.push_back(mk(c + N + 3, m0, l0));
        exp1_q.push_back(mk(c + N + 3, m1, l1));
        exp0_q.push_back(mk(c + 12, m0, 1'b0));
        exp1_q.push_back(mk(c + 12, m1, 1'b0));
        repeat (14) @(negedge clk);
        inc = 1'b0;
        repeat (N + 6) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2, 3: press(1'b1, 1'b0, 1'b0, long_hold(), 0);
                4, 5, 6:    press(1'b0, 1'b1, 1'b0, long_hold(), 0);
                7:          press(1'b0, 1'b0, 1'b1, long_hold(), 0);
                8:          press(1'b1, 1'b1, 1'b0, long_hold(), 0);
                default:    press(1'b1, 1'b0, 1'b0, int'($urandom_range(1, N - 1)), 0);
            endcase
        end

        repeat (N + 20) @(negedge clk);
        done = 1'b1;
    end

    // ---------------- monitor / scoreboard / report ----------------
    always @(negedge clk or posedge rst) begin : mon
        logic [40:0] e;
        bit hit;
        if (rst) begin
            #1;
            total++;
            if ({tens0, ones0, lim0, tens1, ones1, lim1} !== 18'd0) begin
                bad++;
                $display("FAIL reset_state: got %0d%0d lim=%b / %0d%0d lim=%b, need 00 lim=0",
                         tens0, ones0, lim0, tens1, ones1, lim1);
            end
        end else begin
            hit = 1'b0;
            while (exp0_q.size() > 0 && int'(exp0_q[0][40:9]) <= cyc) begin
                e = exp0_q.pop_front();
                total++;
                if (int'(e[40:9]) == cyc) hit = 1'b1;
                if (int'(e[40:9]) != cyc || {tens0, ones0, lim0} !== e[8:0]) begin
                    bad++;
                    $display("FAIL sat_count cyc=%0d: got %0d%0d lim=%b, need %0d%0d lim=%b (due %0d)",
                             cyc, tens0, ones0, lim0, e[8:5], e[4:1], e[0], int'(e[40:9]));
                end
            end
            if (!hit && lim0 !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL sat_limit cyc=%0d: got lim=%b, need 0", cyc, lim0);
            end
            if (tens0 > 4'd9 || ones0 > 4'd9) begin
                total++;
                bad++;
                $display("FAIL sat_digit cyc=%0d: got %0d/%0d, need digits 0..9", cyc, tens0, ones0);
            end

            hit = 1'b0;
            while (exp1_q.size() > 0 && int'(exp1_q[0][40:9]) <= cyc) begin
                e = exp1_q.pop_front();
                total++;
                if (int'(e[40:9]) == cyc) hit = 1'b1;
                if (int'(e[40:9]) != cyc || {tens1, ones1, lim1} !== e[8:0]) begin
                    bad++;
                    $display("FAIL wrap_count cyc=%0d: got %0d%0d lim=%b, need %0d%0d lim=%b (due %0d)",
                             cyc, tens1, ones1, lim1, e[8:5], e[4:1], e[0], int'(e[40:9]));
                end
            end
            if (!hit && lim1 !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL wrap_limit cyc=%0d: got lim=%b, need 0", cyc, lim1);
            end
            if (tens1 > 4'd9 || ones1 > 4'd9) begin
                total++;
                bad++;
                $display("FAIL wrap_digit cyc=%0d: got %0d/%0d, need digits 0..9", cyc, tens1, ones1);
            end

            if (done || cyc > 60000) begin
                total++;
                if (!done || exp0_q.size() != 0 || exp1_q.size() != 0) begin
                    bad++;
                    $display("FAIL drain: got done=%b pending=%0d/%0d, need done=1 pending=0/0",
                             done, exp0_q.size(), exp1_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

endmodule
